// File: rtl/_ram8_pkg.sv
// Shared constants and word type for the RAM hierarchy (_ram8 and the larger levels built on it).
package _ram8_pkg;

    localparam int unsigned WORD_WIDTH      = 16;
    localparam int unsigned RAM8_ADDR_WIDTH = 3;
    localparam int unsigned RAM8_DEPTH      = 8;

    // Bit 0 is the MSB throughout the datapath.
    typedef logic [0:WORD_WIDTH-1] word_t;

    localparam word_t RESET_WORD = '0;

endpackage

// File: rtl/_dmux8way.sv
// 1-to-8 demultiplexer: routes in_ to one of out_a..out_h; sel[0] is the MSB.
module _dmux8way
    import _ram8_pkg::*;
(
    output logic                       out_a,
    output logic                       out_b,
    output logic                       out_c,
    output logic                       out_d,
    output logic                       out_e,
    output logic                       out_f,
    output logic                       out_g,
    output logic                       out_h,
    input  logic                       in_,
    input  logic [0:RAM8_ADDR_WIDTH-1] sel
);

    logic half_lo;
    logic half_hi;

    // sel[0] steers the strobe to the lower (a..d) or upper (e..h) half
    assign half_lo = in_ & ~sel[0];
    assign half_hi = in_ &  sel[0];

    // Lower-half 4-way split on sel[1:2]
    assign out_a = half_lo & ~sel[1] & ~sel[2];
    assign out_b = half_lo & ~sel[1] &  sel[2];
    assign out_c = half_lo &  sel[1] & ~sel[2];
    assign out_d = half_lo &  sel[1] &  sel[2];

    // Upper-half 4-way split on sel[1:2]
    assign out_e = half_hi & ~sel[1] & ~sel[2];
    assign out_f = half_hi & ~sel[1] &  sel[2];
    assign out_g = half_hi &  sel[1] & ~sel[2];
    assign out_h = half_hi &  sel[1] &  sel[2];

endmodule

// File: rtl/_mux8way16.sv
// 8-to-1 word multiplexer: sel[2] picks within a pair, sel[1] within a quad, sel[0] the half.
module _mux8way16
    import _ram8_pkg::*;
(
    output logic [0:WORD_WIDTH-1]      out_y,
    input  logic [0:WORD_WIDTH-1]      in_a,
    input  logic [0:WORD_WIDTH-1]      in_b,
    input  logic [0:WORD_WIDTH-1]      in_c,
    input  logic [0:WORD_WIDTH-1]      in_d,
    input  logic [0:WORD_WIDTH-1]      in_e,
    input  logic [0:WORD_WIDTH-1]      in_f,
    input  logic [0:WORD_WIDTH-1]      in_g,
    input  logic [0:WORD_WIDTH-1]      in_h,
    input  logic [0:RAM8_ADDR_WIDTH-1] sel
);

    logic [0:WORD_WIDTH-1] pair_ab;
    logic [0:WORD_WIDTH-1] pair_cd;
    logic [0:WORD_WIDTH-1] pair_ef;
    logic [0:WORD_WIDTH-1] pair_gh;
    logic [0:WORD_WIDTH-1] quad_lo;
    logic [0:WORD_WIDTH-1] quad_hi;

    // First level: choose within each pair
    assign pair_ab = sel[2] ? in_b : in_a;
    assign pair_cd = sel[2] ? in_d : in_c;
    assign pair_ef = sel[2] ? in_f : in_e;
    assign pair_gh = sel[2] ? in_h : in_g;

    // Second level: choose within each group of four
    assign quad_lo = sel[1] ? pair_cd : pair_ab;
    assign quad_hi = sel[1] ? pair_gh : pair_ef;

    // Final level: choose the half
    assign out_y = sel[0] ? quad_hi : quad_lo;

endmodule

// File: rtl/_register16.sv
// 16-bit load register: per bit a mux(q, d, load) feeding a flop with synchronous reset.
module _register16
    import _ram8_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    output logic [0:WORD_WIDTH-1] out_y,
    input  logic [0:WORD_WIDTH-1] in_a,
    input  logic                  in_load
);

    logic [0:WORD_WIDTH-1] bits_d;
    logic [0:WORD_WIDTH-1] bits_q;

    // Next state: hold unless the load line is asserted
    always_comb begin
        bits_d = bits_q;
        if (in_load) begin
            bits_d = in_a;
        end
    end

    // Storage; reset wins over load
    always_ff @(posedge clk) begin
        if (rst) begin
            bits_q <= RESET_WORD;
        end else begin
            bits_q <= bits_d;
        end
    end

    assign out_y = bits_q;

endmodule

// File: rtl/_ram8.sv
// 8 x 16-bit RAM: dmux steers the load strobe, a word mux reads the addressed register.
module _ram8
    import _ram8_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    output logic [0:WORD_WIDTH-1]      out_y,
    input  logic [0:WORD_WIDTH-1]      in_a,
    input  logic                       in_load,
    input  logic [0:RAM8_ADDR_WIDTH-1] in_address
);

    logic  [0:RAM8_DEPTH-1] load_line;
    word_t                  word_q [RAM8_DEPTH];

    // Write decode: one load line per word
    _dmux8way u_dmux (
        .out_a (load_line[0]),
        .out_b (load_line[1]),
        .out_c (load_line[2]),
        .out_d (load_line[3]),
        .out_e (load_line[4]),
        .out_f (load_line[5]),
        .out_g (load_line[6]),
        .out_h (load_line[7]),
        .in_   (in_load),
        .sel   (in_address)
    );

    // Storage words r0..r7
    for (genvar k = 0; k < int'(RAM8_DEPTH); k++) begin : g_word
        _register16 u_reg (
            .clk     (clk),
            .rst     (rst),
            .out_y   (word_q[k]),
            .in_a    (in_a),
            .in_load (load_line[k])
        );
    end

    // Combinational read of the addressed word; writes are never bypassed
    _mux8way16 u_mux (
        .out_y (out_y),
        .in_a  (word_q[0]),
        .in_b  (word_q[1]),
        .in_c  (word_q[2]),
        .in_d  (word_q[3]),
        .in_e  (word_q[4]),
        .in_f  (word_q[5]),
        .in_g  (word_q[6]),
        .in_h  (word_q[7]),
        .sel   (in_address)
    );

endmodule
